// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller slice.
package snake_pkg;

  localparam int unsigned INIT_LEN = 4;
  localparam int unsigned BOARD_W  = 8;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    DOWN  = 2'b01,
    UP    = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SPAWN,
    ST_RUN,
    ST_STEP,
    ST_EVAL,
    ST_OVER
  } ctrl_state_t;

  // The encoding makes opposite directions bitwise complements.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/snake_lfsr6.sv
// 6-bit maximal-length LFSR (x^6+x^5+1); free-running, seeded to 000001, never zero.
module snake_lfsr6
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  output logic [5:0] q
);

  logic [5:0] lfsr_q;
  logic [5:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  end

  always_ff @(posedge clk) begin
    if (!clear_n) lfsr_q <= 6'b000001;
    else          lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow sequencer for the 8x8 snake datapath: play/over FSM, direction latch, step and spawn handshakes.
// Define SNAKE_SPEEDUP_EN to gate steps with a score-dependent tick-skip counter.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned INIT_LEN      = snake_pkg::INIT_LEN,
  parameter int unsigned MAX_LEN       = 64,
  parameter int unsigned TICK_DIV_BASE = 4
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] direction,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_done,
  input  logic       hit_wall,
  input  logic       hit_self,
  input  logic       ate,
  output logic       grow,
  output logic       board_init,
  output logic       spawn_req,
  output logic [5:0] spawn_xy,
  input  logic       spawn_ack,
  output logic [5:0] score,
  output logic       game_over,
  output logic       win
);

  ctrl_state_t state_q, state_d;
  dir_t        dir_q, dir_d;
  dir_t        last_dir_q, last_dir_d;
  dir_t        step_dir_q, step_dir_d;
  dir_t        btn_dir;
  logic        step_req_q, step_req_d;
  logic        grow_q, grow_d;
  logic        board_init_q, board_init_d;
  logic        spawn_req_q, spawn_req_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;
  logic        coll_q, coll_d;
  logic        ate_q, ate_d;
  logic [5:0]  score_q, score_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  len_inc;
  logic [5:0]  score_inc;
  logic        step_go;

  snake_lfsr6 u_lfsr (
    .clk     (clk),
    .clear_n (clear_n),
    .q       (spawn_xy)
  );

`ifdef SNAKE_SPEEDUP_EN
  logic [5:0] skip_q, skip_d;
  logic [5:0] base, quarter, period;

  // skip_q counts ticks seen in RUN since the last step; period shrinks by one every 4 apples.
  always_comb begin
    base    = 6'(TICK_DIV_BASE);
    quarter = {2'b00, score_q[5:2]};
    period  = (base > quarter) ? base - quarter : 6'd1;
    step_go = (skip_q + 6'd1) >= period;
    skip_d  = skip_q;
    if ((state_q == ST_IDLE || state_q == ST_OVER) && start) skip_d = '0;
    else if (state_q == ST_RUN && tick)                    skip_d = step_go ? '0 : skip_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) skip_q <= '0;
    else          skip_q <= skip_d;
  end
`else
  always_comb begin
    step_go = 1'b1;
  end
`endif

  always_comb begin
    btn_dir = UP;
    if (direction[3])      btn_dir = RIGHT;
    else if (direction[0]) btn_dir = LEFT;
    else if (direction[1]) btn_dir = DOWN;
  end

  always_comb begin
    len_inc   = (len_q >= 7'(MAX_LEN)) ? len_q : len_q + 7'd1;
    score_inc = (score_q == '1) ? score_q : score_q + 6'd1;

    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    step_dir_d = step_dir_q;
    score_d    = score_q;
    len_d      = len_q;
    win_d      = win_q;
    coll_d     = coll_q;
    ate_d      = ate_q;
    grow_d     = 1'b0;

    if ((state_q == ST_RUN || state_q == ST_STEP || state_q == ST_EVAL) &&
        (|direction) && !is_reverse(btn_dir, last_dir_q)) begin
      dir_d = btn_dir;
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d    = ST_INIT;
          score_d    = '0;
          len_d      = 7'(INIT_LEN);
          win_d      = 1'b0;
          dir_d      = RIGHT;
          last_dir_d = RIGHT;
          step_dir_d = RIGHT;
        end
      end
      ST_INIT:  state_d = ST_SPAWN;
      ST_SPAWN: if (spawn_ack) state_d = ST_RUN;
      ST_RUN: begin
        if (tick && step_go) begin
          state_d    = ST_STEP;
          step_dir_d = dir_d;
        end
      end
      ST_STEP: begin
        if (step_done) begin
          state_d    = ST_EVAL;
          coll_d     = hit_wall | hit_self;
          ate_d      = ate;
          last_dir_d = step_dir_q;
        end
      end
      ST_EVAL: begin
        if (coll_q) begin
          state_d = ST_OVER;
        end else if (ate_q) begin
          grow_d  = 1'b1;
          score_d = score_inc;
          len_d   = len_inc;
          if (len_inc == 7'(MAX_LEN)) begin
            state_d = ST_OVER;
            win_d   = 1'b1;
          end else begin
            state_d = ST_SPAWN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Level outputs are registered from the next state so they line up with state_q.
    step_req_d   = (state_d == ST_STEP);
    spawn_req_d  = (state_d == ST_SPAWN);
    board_init_d = (state_d == ST_INIT);
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= RIGHT;
      last_dir_q   <= RIGHT;
      step_dir_q   <= RIGHT;
      step_req_q   <= 1'b0;
      grow_q       <= 1'b0;
      board_init_q <= 1'b0;
      spawn_req_q  <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
      coll_q       <= 1'b0;
      ate_q        <= 1'b0;
      score_q      <= '0;
      len_q        <= 7'(INIT_LEN);
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      last_dir_q   <= last_dir_d;
      step_dir_q   <= step_dir_d;
      step_req_q   <= step_req_d;
      grow_q       <= grow_d;
      board_init_q <= board_init_d;
      spawn_req_q  <= spawn_req_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
      coll_q       <= coll_d;
      ate_q        <= ate_d;
      score_q      <= score_d;
      len_q        <= len_d;
    end
  end

  assign step_req   = step_req_q;
  assign step_dir   = step_dir_q;
  assign grow       = grow_q;
  assign board_init = board_init_q;
  assign spawn_req  = spawn_req_q;
  assign score      = score_q;
  assign game_over  = game_over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl; expected step directions are queued at stimulus time.
module tb_snake_game_ctrl;

  localparam int unsigned MAXL = 24;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] direction = '0;
  logic       step_done = 1'b0;
  logic       hit_wall = 1'b0;
  logic       hit_self = 1'b0;
  logic       ate = 1'b0;
  logic       spawn_ack = 1'b0;
  logic       step_req, grow, board_init, spawn_req, game_over, win;
  logic [1:0] step_dir;
  logic [5:0] spawn_xy, score;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_dir_q[$];
  int exp_score = 0;
  int exp_len = 4;
  logic [5:0] xy0, xy1, xy2;

  snake_game_ctrl #(
    .INIT_LEN      (4),
    .MAX_LEN       (MAXL),
    .TICK_DIV_BASE (4)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .tick       (tick),
    .start      (start),
    .direction  (direction),
    .step_req   (step_req),
    .step_dir   (step_dir),
    .step_done  (step_done),
    .hit_wall   (hit_wall),
    .hit_self   (hit_self),
    .ate        (ate),
    .grow       (grow),
    .board_init (board_init),
    .spawn_req  (spawn_req),
    .spawn_xy   (spawn_xy),
    .spawn_ack  (spawn_ack),
    .score      (score),
    .game_over  (game_over),
    .win        (win)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_period(input int sc);
    int p;
    p = 1;
`ifdef SNAKE_SPEEDUP_EN
    p = 4 - sc / 4;
    if (p < 1) p = 1;
`else
    if (sc < 0) p = 1;
`endif
    return p;
  endfunction

  // Pulse ticks (one idle cycle between) until step_req rises; n = ticks issued.
  task automatic tick_until_step(output int n);
    n = 0;
    while (step_req !== 1'b1 && n < 16) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      n++;
      if (step_req !== 1'b1) cyc();
    end
  endtask

  task automatic run_step(input logic [1:0] edir, input logic [3:0] btn,
                          input logic a, input logic w, input int nt);
    int n;
    exp_dir_q.push_back(edir);
    tick_until_step(n);
    chk("step_ticks", 8'(n), 8'(nt));
    chk("step_req_on", {7'b0, step_req}, 8'd1);
    chk("step_dir", {6'b0, step_dir}, {6'b0, exp_dir_q.pop_front()});
    direction = btn;
    cyc();
    cyc();
    direction = '0;
    chk("step_dir_frozen", {6'b0, step_dir}, {6'b0, edir});
    chk("step_req_held", {7'b0, step_req}, 8'd1);
    step_done = 1'b1;
    ate = a;
    hit_wall = w;
    cyc();
    step_done = 1'b0;
    ate = 1'b0;
    hit_wall = 1'b0;
    chk("step_req_drop", {7'b0, step_req}, 8'd0);
    cyc();
  endtask

  task automatic do_spawn();
    int n;
    n = 0;
    while (spawn_req !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    chk("spawn_req_on", {7'b0, spawn_req}, 8'd1);
    chk("spawn_xy_nonzero", {7'b0, (spawn_xy != 6'd0)}, 8'd1);
    spawn_ack = 1'b1;
    cyc();
    spawn_ack = 1'b0;
    chk("spawn_req_drop", {7'b0, spawn_req}, 8'd0);
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    exp_score = 0;
    exp_len = 4;
    chk("board_init_on", {7'b0, board_init}, 8'd1);
    chk("init_score", {2'b0, score}, 8'd0);
    chk("init_game_over", {7'b0, game_over}, 8'd0);
    cyc();
    chk("board_init_pulse", {7'b0, board_init}, 8'd0);
  endtask

  initial begin
    int n;
    logic [1:0] cur;

    // Reset state
    cyc();
    cyc();
    clear_n = 1'b1;
    chk("rst_step_req", {7'b0, step_req}, 8'd0);
    chk("rst_step_dir", {6'b0, step_dir}, 8'd3);
    chk("rst_score", {2'b0, score}, 8'd0);
    chk("rst_game_over", {7'b0, game_over}, 8'd0);
    chk("rst_win", {7'b0, win}, 8'd0);
    chk("rst_spawn_req", {7'b0, spawn_req}, 8'd0);
    chk("rst_grow", {7'b0, grow}, 8'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("idle_tick_ignored", {7'b0, step_req}, 8'd0);

    // Start, spawn with ack withheld for 3 cycles
    start_game();
    xy0 = spawn_xy;
    cyc();
    xy1 = spawn_xy;
    cyc();
    xy2 = spawn_xy;
    chk("spawn_xy_distinct",
        {7'b0, (xy0 != xy1 && xy1 != xy2 && xy0 != xy2 && xy0 != 0 && xy1 != 0 && xy2 != 0)}, 8'd1);
    do_spawn();
    cyc();

    // Steps and direction latch; start held high during RUN must be ignored
    start = 1'b1;
    run_step(2'b11, 4'b0001, 1'b0, 1'b0, exp_period(0));
    start = 1'b0;
    chk("start_ignored_run", {7'b0, board_init | spawn_req | game_over}, 8'd0);
    run_step(2'b11, 4'b0100, 1'b0, 1'b0, exp_period(0));
    run_step(2'b10, 4'b0000, 1'b0, 1'b0, exp_period(0));
    run_step(2'b10, 4'b0010, 1'b0, 1'b0, exp_period(0));
    run_step(2'b10, 4'b1000, 1'b0, 1'b0, exp_period(0));
    chk("plain_step_grow", {7'b0, grow}, 8'd0);
    chk("plain_step_score", {2'b0, score}, 8'd0);
    cur = 2'b11;

    // Eat until the length reaches MAXL (win)
    for (int unsigned k = 0; k < 20; k++) begin
      run_step(cur, 4'b0000, 1'b1, 1'b0, exp_period(exp_score));
      if (exp_score < 63) exp_score++;
      exp_len++;
      chk("eat_score", {2'b0, score}, 8'(exp_score));
      chk("eat_grow", {7'b0, grow}, 8'd1);
      if (exp_len == int'(MAXL)) begin
        chk("win_game_over", {7'b0, game_over}, 8'd1);
        chk("win_flag", {7'b0, win}, 8'd1);
        chk("win_no_spawn", {7'b0, spawn_req}, 8'd0);
        break;
      end
      chk("eat_spawn_req", {7'b0, spawn_req}, 8'd1);
      cyc();
      chk("grow_pulse", {7'b0, grow}, 8'd0);
      if (k == 0) begin
        tick = 1'b1;
        cyc();
        tick = 1'b0;
      end
      do_spawn();
      if (k == 0) begin
        cyc();
        cyc();
        chk("spawn_tick_dropped", {7'b0, step_req}, 8'd0);
      end
      cyc();
    end

    // Game 2: collision beats ate
    start_game();
    do_spawn();
    cyc();
    run_step(2'b11, 4'b0000, 1'b1, 1'b1, exp_period(0));
    chk("coll_game_over", {7'b0, game_over}, 8'd1);
    chk("coll_score", {2'b0, score}, 8'd0);
    chk("coll_grow", {7'b0, grow}, 8'd0);
    chk("coll_win", {7'b0, win}, 8'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("over_tick_ignored", {7'b0, step_req}, 8'd0);

    // Game 3: reset in the middle of a step
    start_game();
    do_spawn();
    cyc();
    run_step(2'b11, 4'b0000, 1'b1, 1'b0, exp_period(0));
    chk("g3_score", {2'b0, score}, 8'd1);
    do_spawn();
    direction = 4'b0100;
    cyc();
    direction = '0;
    tick_until_step(n);
    chk("g3_step_req", {7'b0, step_req}, 8'd1);
    chk("g3_step_dir", {6'b0, step_dir}, 8'd2);
    clear_n = 1'b0;
    cyc();
    clear_n = 1'b1;
    chk("midstep_rst_step_req", {7'b0, step_req}, 8'd0);
    chk("midstep_rst_score", {2'b0, score}, 8'd0);
    chk("midstep_rst_game_over", {7'b0, game_over}, 8'd0);
    chk("midstep_rst_step_dir", {6'b0, step_dir}, 8'd3);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    chk("post_rst_idle", {6'b0, step_req, spawn_req}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
